series_eval_unit: RTL and testbench

SERIES_EVAL_UNIT -- requirements
Module: series_eval_unit

---
 rtl/series_eval_unit.sv | 139 +++++++++++++
 tb/tb_series_eval_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/series_eval_unit.sv
// rtl/series_eval_unit.sv - iterative exp(x) / ln(1+x) / exp(-x) power-series evaluator
// Build macro SERIES_EVAL_ROUND_EN selects round-half-up products instead of truncation.
module series_eval_unit #(
  parameter int W       = 16,
  parameter int N_TERMS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [W-1:0] xBus,
  output logic [W+1:0] rBus,
  output logic         busy,
  output logic         done,
  output logic         err
);
  localparam int KW = $clog2(N_TERMS + 2);
  localparam int RN = 1 << KW;
  localparam logic [W+1:0] ONE = {2'b01, {W{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_MULX, S_MULC, S_ACC, S_DONE} state_t;
  state_t r_state, w_next;

  logic [W-1:0]   r_x, r_p, r_t;
  logic [W+1:0]   r_a;
  logic [KW-1:0]  r_k;
  logic [1:0]     r_mode;

  logic [W-1:0]   w_r_tab [RN];
  logic [W-1:0]   w_mul_b, w_trunc;
  logic [2*W-1:0] w_prod;
  logic [W+2:0]   w_sum;
  logic [W+1:0]   w_acc;
  logic           w_sub;

  // Reciprocal table R(k) = floor(2^W / k), elaborated from the parameters
  for (genvar j = 0; j < RN; j++) begin : g_rtab
    if (j >= 2 && j <= N_TERMS) begin : g_on
      localparam longint RK = (longint'(1) << W) / longint'(j);
      assign w_r_tab[j] = RK[W-1:0];
    end else begin : g_off
      assign w_r_tab[j] = '0;
    end
  end

  // One shared multiplier: P*x in MULX, P*R(k) in MULC
  assign w_mul_b = (r_state == S_MULX) ? r_x : w_r_tab[r_k];
`ifdef SERIES_EVAL_ROUND_EN
  assign w_prod  = (2*W)'(r_p) * (2*W)'(w_mul_b) + ((2*W)'(1) << (W-1));
`else
  assign w_prod  = (2*W)'(r_p) * (2*W)'(w_mul_b);
`endif
  assign w_trunc = W'(w_prod >> W);

  assign w_sub = ((r_mode == 2'b01) && !r_k[0]) || ((r_mode == 2'b10) && r_k[0]);
  assign w_sum = {1'b0, r_a} + {3'b000, r_t};

  always_comb begin
    w_acc = w_sum[W+1:0];
    if (w_sub) begin
      w_acc = (r_a < {2'b00, r_t}) ? '0 : r_a - {2'b00, r_t};
    end else if (w_sum[W+2]) begin
      w_acc = '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_INIT;
      S_INIT: begin
        busy   = 1'b1;
        w_next = (r_mode == 2'b11) ? S_DONE : S_MULX;
      end
      S_MULX: begin busy = 1'b1; w_next = S_MULC; end
      S_MULC: begin busy = 1'b1; w_next = S_ACC; end
      S_ACC: begin
        busy   = 1'b1;
        w_next = (r_k < KW'(N_TERMS)) ? S_MULX : S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        err  = (r_mode == 2'b11);
        if (!start) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operands are latched on the accepting edge, so bus activity while busy is ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x    <= '0;
      r_p    <= '0;
      r_t    <= '0;
      r_a    <= '0;
      r_k    <= '0;
      r_mode <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_x    <= xBus;
          r_mode <= mode;
        end
        S_INIT: begin
          r_k <= KW'(1);
          r_p <= r_x;
          r_t <= '0;
          r_a <= (r_mode == 2'b00 || r_mode == 2'b10) ? ONE : '0;
        end
        S_MULX: if (r_k != KW'(1)) r_p <= w_trunc;
        S_MULC: begin
          if (r_k == KW'(1)) begin
            r_t <= r_p;
          end else begin
            r_t <= w_trunc;
            if (r_mode != 2'b01) r_p <= w_trunc;
          end
        end
        S_ACC: begin
          r_a <= w_acc;
          r_k <= r_k + KW'(1);
        end
        default: ;
      endcase
    end
  end

  assign rBus = r_a;

endmodule

// File: tb/tb_series_eval_unit.sv
// tb/tb_series_eval_unit.sv - randomized self-checking bench for series_eval_unit (W=16, N_TERMS=8)
module tb_series_eval_unit;
  localparam int W  = 16;
  localparam int NT = 8;
  localparam int LAT = 1 + 3 * NT;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  mode;
  logic [15:0] xBus;
  logic [17:0] rBus;
  logic        busy, done, err;
  int n_checks = 0;
  int n_fail   = 0;

  series_eval_unit #(.W(W), .N_TERMS(NT)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .xBus(xBus),
    .rBus(rBus), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic longint tr(input longint v);
`ifdef SERIES_EVAL_ROUND_EN
    return (v + 32768) >>> 16;
`else
    return v >>> 16;
`endif
  endfunction

  // Series sum: term_k = x^k/k! (exp) or x^k/k (ln), signs alternating as each function requires
  function automatic logic [17:0] model(input logic [1:0] m, input logic [15:0] x);
    longint a, p, t, xx;
    bit     neg;
    if (m == 2'b11) return 18'd0;
    xx = longint'(x);
    a  = (m == 2'b01) ? 0 : 65536;
    p  = xx;
    for (int k = 1; k <= NT; k++) begin
      if (k == 1) t = p;
      else if (m == 2'b01) begin
        p = tr(p * xx);
        t = tr(p * (65536 / k));
      end else begin
        p = tr(tr(p * xx) * (65536 / k));
        t = p;
      end
      neg = (m == 2'b01) ? (k % 2 == 0) : (m == 2'b10) ? (k % 2 == 1) : 1'b0;
      a = neg ? a - t : a + t;
      if (a < 0) a = 0;
      if (a > 262143) a = 262143;
    end
    return a[17:0];
  endfunction

  task automatic run_op(input logic [1:0] m, input logic [15:0] x, output int cyc,
                        output logic [17:0] r, output logic e, output logic busy_ok);
    @(negedge clk);
    start = 1'b1; mode = m; xBus = x;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; busy_ok = 1'b1;
    while (!done && cyc < 200) begin
      if (!busy) busy_ok = 1'b0;
      mode = 2'($urandom); xBus = 16'($urandom); start = 1'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    r = rBus; e = err;
    if (busy) busy_ok = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; mode = 2'b00; xBus = 16'h0;
    #1;
    n_checks++;
    if ({rBus, busy, done, err} !== 21'd0) begin
      n_fail++; $display("FAIL reset_outputs: rBus=%h busy=%b done=%b err=%b, required all 0", rBus, busy, done, err);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_exp;
    int cyc; logic [17:0] r; logic e, bok; int d;
    run_op(2'b00, 16'h0000, cyc, r, e, bok);
    n_checks++;
    if (cyc != LAT) begin n_fail++; $display("FAIL exp0_latency: got %0d cycles, required %0d", cyc, LAT); end
    n_checks++;
    if (r !== 18'h10000 || e !== 1'b0) begin n_fail++; $display("FAIL exp0_result: rBus=%h err=%b, required 10000 err=0", r, e); end
    n_checks++;
    if (!bok) begin n_fail++; $display("FAIL exp0_busy: busy=%b, required 1 while running and 0 in DONE", bok); end
    n_checks++;
    if (rBus !== 18'h10000 || done !== 1'b0) begin n_fail++; $display("FAIL idle_hold: rBus=%h done=%b, required 10000 done=0", rBus, done); end
    run_op(2'b00, 16'h8000, cyc, r, e, bok);
    d = int'(r) - 'h1A613; if (d < 0) d = -d;
    n_checks++;
    if (d > 8 || r !== model(2'b00, 16'h8000)) begin
      n_fail++; $display("FAIL exp_half: rBus=%h, required %h (near 1a613)", r, model(2'b00, 16'h8000));
    end
  endtask

  task automatic test_ln;
    int cyc; logic [17:0] r; logic e, bok; int d;
    run_op(2'b01, 16'h8000, cyc, r, e, bok);
    d = int'(r) - 'h067C2; if (d < 0) d = -d;
    n_checks++;
    if (d > 8 || r !== model(2'b01, 16'h8000) || cyc != LAT) begin
      n_fail++; $display("FAIL ln_half: rBus=%h cyc=%0d, required %h cyc=%0d", r, cyc, model(2'b01, 16'h8000), LAT);
    end
    run_op(2'b01, 16'h0000, cyc, r, e, bok);
    n_checks++;
    if (r !== 18'd0 || e !== 1'b0) begin n_fail++; $display("FAIL ln_zero: rBus=%h err=%b, required 0 err=0", r, e); end
  endtask

  task automatic test_expneg;
    int cyc; logic [17:0] r; logic e, bok; int d;
    run_op(2'b10, 16'hFFFF, cyc, r, e, bok);
    d = int'(r) - 'h05E2D; if (d < 0) d = -d;
    n_checks++;
    if (d > 16 || r !== model(2'b10, 16'hFFFF)) begin
      n_fail++; $display("FAIL expneg_one: rBus=%h, required %h (near 05e2d)", r, model(2'b10, 16'hFFFF));
    end
  endtask

  task automatic test_mode11;
    @(negedge clk);
    start = 1'b1; mode = 2'b11; xBus = 16'($urandom);
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL m11_init: done=%b busy=%b, required 0 1", done, busy); end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b1 || err !== 1'b1 || rBus !== 18'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL m11_done: done=%b err=%b rBus=%h busy=%b, required 1 1 0 0", done, err, rBus, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL m11_hold: done=%b err=%b, required 1 1", done, err); end
    start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL m11_release: done=%b err=%b busy=%b, required 0 0 0", done, err, busy);
    end
  endtask

  task automatic test_reset_mid;
    int cyc; logic [17:0] r; logic e, bok; logic [15:0] x;
    @(negedge clk);
    start = 1'b1; mode = 2'b00; xBus = 16'h8000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({rBus, busy, done, err} !== 21'd0) begin
      n_fail++; $display("FAIL reset_mid_async: rBus=%h busy=%b done=%b err=%b, required all 0", rBus, busy, done, err);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({rBus, busy, done, err} !== 21'd0) begin
      n_fail++; $display("FAIL reset_mid_next: rBus=%h busy=%b done=%b err=%b, required all 0", rBus, busy, done, err);
    end
    @(negedge clk);
    rst = 1'b0;
    x = 16'($urandom);
    run_op(2'b00, x, cyc, r, e, bok);
    n_checks++;
    if (r !== model(2'b00, x) || cyc != LAT || !bok) begin
      n_fail++; $display("FAIL reset_recover: rBus=%h cyc=%0d, required %h cyc=%0d", r, cyc, model(2'b00, x), LAT);
    end
  endtask

  task automatic test_back_to_back;
    int cyc; logic [17:0] r; logic e, bok; logic [1:0] m; logic [15:0] x;
    for (int i = 0; i < 24; i++) begin
      m = 2'($urandom);
      x = (i < 2) ? (i == 0 ? 16'hFFFF : 16'h0001) : 16'($urandom);
      run_op(m, x, cyc, r, e, bok);
      n_checks++;
      if (r !== model(m, x) || e !== (m == 2'b11) || cyc != ((m == 2'b11) ? 1 : LAT) || !bok) begin
        n_fail++;
        $display("FAIL random_op%0d mode=%b x=%h: rBus=%h err=%b cyc=%0d busy_ok=%b, required rBus=%h err=%b cyc=%0d",
                 i, m, x, r, e, cyc, bok, model(m, x), (m == 2'b11), (m == 2'b11) ? 1 : LAT);
      end
    end
  endtask

  initial begin
    test_reset;
    test_exp;
    test_ln;
    test_expneg;
    test_mode11;
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
